// File: rtl/ssd_scan_ctrl_if.sv
// Bundles the score-side and decoder-side signals of the seven-segment scan controller.
// The master side is the score logic / decoder / pins; the slave side is the controller.
interface ssd_scan_ctrl_if #(
  parameter int VAL_W = 14
);
  logic             load;
  logic [VAL_W-1:0] value_in;
  logic             disp_en;
  logic [3:0]       digit_code;
  logic [7:0]       ssd_in;
  logic [7:0]       seg_n;
  logic [3:0]       an_n;
  logic             busy;

  modport master (
    output load, value_in, disp_en, ssd_in,
    input  digit_code, seg_n, an_n, busy
  );

  modport slave (
    input  load, value_in, disp_en, ssd_in,
    output digit_code, seg_n, an_n, busy
  );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller: a sequential double-dabble converter feeds
// a committed digit register, which a free-running scanner presents one digit per refresh slot.
module ssd_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int VAL_W       = 14,
  parameter int MAX_VAL     = 9999
) (
  input  logic clk,
  input  logic rst,
  ssd_scan_ctrl_if.slave bus
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(VAL_W + 1);
  localparam logic [VAL_W-1:0] MAX_V = VAL_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

  state_e           state_q, state_d;
  logic [VAL_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [SW-1:0]    step_q, step_d;
  logic             pend_q, pend_d;
  logic [VAL_W-1:0] pendVal_q, pendVal_d;
  logic [15:0]      digits_q, digits_d;

  logic [VAL_W-1:0] clampVal;
  logic [15:0]      bcdAdj;

  logic [CW-1:0]    refCnt_q, refCnt_d;
  logic [1:0]       slot_q, slotNext;
  logic [3:0]       code_q, codeNext;
  logic [3:0]       an_q, anNext;
  logic             wrap;
  logic             blankNext;

  assign clampVal = (bus.value_in > MAX_V) ? MAX_V : bus.value_in;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bcdAdj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end
  end

  // A load arriving while a conversion is running is parked and started straight from COMMIT.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    step_d    = step_q;
    pend_d    = pend_q;
    pendVal_d = pendVal_q;
    digits_d  = digits_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          bin_d   = clampVal;
          bcd_d   = '0;
          step_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
        step_d = step_q + SW'(1);
        if (step_q == SW'(VAL_W - 1)) begin
          state_d = COMMIT;
        end
        if (bus.load) begin
          pend_d    = 1'b1;
          pendVal_d = clampVal;
        end
      end
      COMMIT: begin
        digits_d = bcd_q;
        if (bus.load || pend_q) begin
          bin_d   = bus.load ? clampVal : pendVal_q;
          bcd_d   = '0;
          step_d  = '0;
          pend_d  = 1'b0;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      step_q    <= '0;
      pend_q    <= 1'b0;
      pendVal_q <= '0;
      digits_q  <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      step_q    <= step_d;
      pend_q    <= pend_d;
      pendVal_q <= pendVal_d;
      digits_q  <= digits_d;
    end
  end

  assign wrap     = (refCnt_q == CW'(REFRESH_DIV - 1));
  assign refCnt_d = wrap ? '0 : refCnt_q + CW'(1);
  assign slotNext = slot_q + 2'd1;

  // Slot k above zero stays dark while every digit from k upward is zero.
  always_comb begin
    codeNext  = 4'd0;
    blankNext = 1'b0;
    case (slotNext)
      2'd0: begin
        codeNext  = digits_q[3:0];
        blankNext = 1'b0;
      end
      2'd1: begin
        codeNext  = digits_q[7:4];
        blankNext = (digits_q[15:4] == 12'd0);
      end
      2'd2: begin
        codeNext  = digits_q[11:8];
        blankNext = (digits_q[15:8] == 8'd0);
      end
      default: begin
        codeNext  = digits_q[15:12];
        blankNext = (digits_q[15:12] == 4'd0);
      end
    endcase
    anNext = (!bus.disp_en || blankNext) ? 4'b1111 : ~(4'b0001 << slotNext);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refCnt_q <= '0;
      slot_q   <= 2'd0;
      code_q   <= 4'd0;
      an_q     <= 4'b1110;
    end else begin
      refCnt_q <= refCnt_d;
      if (wrap) begin
        slot_q <= slotNext;
        code_q <= codeNext;
        an_q   <= anNext;
      end
    end
  end

  assign bus.digit_code = code_q;
  assign bus.an_n       = an_q;
  assign bus.seg_n      = bus.ssd_in;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Drives a 4-digit common-anode seven-segment display through one shared binary-to-SSD decoder.
- Converts a binary score to BCD with a sequential double-dabble engine.
- Time-multiplexes the four BCD digits onto the shared decoder input, one digit per refresh slot, and drives the matching anode.
- Sits between the game score logic and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot; legal range 2 to 2^20.
- VAL_W, 14, width of the binary value input.
- MAX_VAL, 9999, saturation limit applied to the input value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  single-cycle strobe; sample value_in
- value_in  in  VAL_W  unsigned binary value to display
- disp_en  in  1  0 forces all anodes off
- digit_code  out  4  BCD nibble to the shared decoder input
- ssd_in  in  8  segment pattern returned by the decoder; active-low; bit0 = DP
- seg_n  out  8  segments to pins; equals ssd_in combinationally
- an_n  out  4  active-low anodes; bit k = digit k; digit 0 = least significant
- busy  out  1  conversion in progress

Behaviour:
- Reset (async, rst=1):
  - Display digits d3..d0 = 0; digit_code = 0; an_n = 4'b1110; busy = 0.
  - Refresh counter = 0; slot index = 0; pending flag cleared; FSM = IDLE.
- Conversion FSM has three states: IDLE, CONV, COMMIT.
- IDLE:
  - On load=1, capture min(value_in, MAX_VAL) into the shift register, clear the BCD accumulator and shift count, then go to CONV.
  - busy rises on the next edge.
- CONV: one double-dabble step per cycle. The step is: add 3 to each BCD nibble that is >= 5, then shift {bcd, bin} left by 1. After exactly VAL_W steps, go to COMMIT.
- COMMIT: copy the accumulator into d3..d0 in one cycle, then go to IDLE, or to CONV if a load is pending. busy=0 in IDLE only.
- Latency: a load sampled at edge N gives d3..d0 updated at edge N+VAL_W+1 (N+15 at default). busy is high from N+1 through N+VAL_W+1.
- Load while busy:
  - Latch the clamped value into a one-deep pending register; a newer load overwrites it.
  - The current conversion is never aborted.
  - The pending value starts CONV directly from COMMIT; busy stays high throughout.
- load and COMMIT in the same cycle: the load becomes the pending value and is still honoured.
- Display digits change only in COMMIT, so the display never shows a partial conversion.
- Scanner (runs independently of the FSM):
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap edge, the slot index advances 0→1→2→3→0.
  - digit_code and an_n are both registered on that same edge, for the new slot, so they stay aligned.
- Anode drive:
  - an_n = one-hot-low of the slot index, except when the slot is blanked or disp_en=0; then an_n = 4'b1111.
- Leading-zero blanking:
  - Slot k (k ≥ 1) is blanked when dk..d3 are all 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A blanked slot still drives digit_code = dk.
- disp_en is sampled at the slot-advance edge; the scan continues while it is 0.
- seg_n = ssd_in with no register; the decoder must be purely combinational.
- Inputs above MAX_VAL saturate: 12000 displays 9999.

Test Plan:
- Reset check: rst pulse mid-scan → an_n=1110, digit_code=0, busy=0 immediately (async), without waiting for a clock edge.
- Basic conversion: REFRESH_DIV=4, load value_in=1234 → busy high 15 cycles; d3..d0=1,2,3,4. Then for 16 cycles, digit_code/an_n step through 4/1110, 3/1101, 2/1011, 1/0111 at 4-cycle intervals.
- Leading-zero blanking:
  - Load 7 → an_n shows 1110 with digit_code 7; slots 1–3 show an_n=1111.
  - Load 0 → only slot 0 is lit, digit_code 0.
  - Load 1005 → all four slots are lit.
- Saturation: load value_in=16383 → display 9999.
- Load during busy: load 42, then at +3 cycles load 77, then at +5 cycles load 500 → display shows 42, then 500; 77 is never committed; busy stays high continuously until the 500 commit.
- disp_en=0 for 2 slots → an_n=1111 for those slots; the slot sequence resumes with no skipped index when disp_en returns to 1.
